mem_bus_unit: RTL and testbench
===============================

Name: mem_bus_unit

Overview:
- Multicycle memory-access controller that replaces the bare MAR/MDR pair and raw MOC handshake in the CPU datapath.
- Accepts one load/store request from the control FSM and registers address and data (MAR/MDR role).
- Drives the memory enable/rw/MOC handshake, with byte lanes, sign/zero extension, an endianness mode and a MOC timeout.
- Reports completion and error causes back to the control unit.

Parameters:
ADDR_W, 32, address width; mem_addr is word-aligned (low 2 bits forced 0)
TIMEOUT, 15, max cycles in ACCESS without MOC before timeout error (>=1)
CNT_W, 4, timeout counter width; must hold TIMEOUT
BIG_ENDIAN, 1, 1: byte at addr[1:0]=0 is bits [31:24]; 0: bits [7:0]

Ports:
clk  in  1  clock; everything on rising edge
reset  in  1  synchronous, active-high
req  in  1  start request; sampled only in IDLE
wr  in  1  1=store, 0=load
size  in  2  00 byte, 01 half, 10 word, 11 invalid
unsign  in  1  loads: 1=zero-extend, 0=sign-extend
addr  in  ADDR_W  byte address
wdata  in  32  store data, right-justified
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle completion pulse
err  out  1  high with done when the request failed
err_cause  out  2  00 ok, 01 misaligned, 10 timeout, 11 bad size; valid with done, held until next done
rdata  out  32  extended load result; updated only on successful load, held otherwise
mem_enable  out  1  memory enable
mem_rw  out  1  1=read, 0=write (matches existing memory model)
mem_addr  out  ADDR_W  registered word address
mem_wdata  out  32  lane-replicated store data
mem_be  out  4  byte enables, bit i = bits [8i+7:8i]
mem_rdata  in  32  memory read word
mem_moc  in  1  memory operation complete

Behaviour:
- States: IDLE, ACCESS, COMPLETE, RELEASE. Reset (any state, including mid-access) -> IDLE. Reset values: busy=0, done=0, err=0, err_cause=00, rdata=0, mem_enable=0, mem_rw=1, mem_addr=0, mem_wdata=0, mem_be=0, counter=0.
- IDLE + req:
  - Register addr, wr, size, unsign, and the lane-formatted wdata/mem_be.
  - Check the request: size=11 -> bad size; half with addr[0]=1 or word with addr[1:0]!=0 -> misaligned.
  - Error -> go to COMPLETE with no memory access (mem_enable stays 0); done+err appear on the next cycle.
  - Otherwise -> ACCESS; counter cleared.
- ACCESS: mem_enable=1, mem_rw=~wr; counter increments each cycle.
  - mem_moc=1 sampled: on a load, capture the extended mem_rdata into rdata; go to COMPLETE with err_cause=00.
  - counter reaches TIMEOUT with mem_moc=0: go to COMPLETE with err_cause=10; rdata unchanged. MOC wins if it coincides with the TIMEOUT cycle.
- COMPLETE: mem_enable=0; done=1 for exactly one cycle; err=(err_cause!=00).
  - Next state: RELEASE if mem_moc=1, else IDLE.
- RELEASE: wait for mem_moc=0, then IDLE. No done pulse. Protects the level-based MOC model from double completion.
- Minimum latency: req cycle T, mem_enable high from T+1, MOC at T+1 -> done at T+2.
- Byte lane L: BIG_ENDIAN=1 gives L = 3 - addr[1:0]; BIG_ENDIAN=0 gives L = addr[1:0]. Half lanes are computed the same way from addr[1].
- Store formatting:
  - byte: wdata[7:0] replicated to all 4 lanes, mem_be = 1<<L.
  - half: wdata[15:0] replicated to both halves, mem_be = 0011 or 1100.
  - word: mem_be = 1111.
- Load extraction: select the lane(s), then extend to 32 bits per unsign.
- Loads drive mem_be = 1111.
- req while busy is ignored; no queuing.

Test Plan:
1. BIG_ENDIAN=1, word store addr=0x10, wdata=0xDEADBEEF, MOC after 3 cycles -> mem_addr=0x10, mem_be=1111, mem_rw=0, mem_enable high 3 cycles, done at T+4, err=0.
2. Byte load addr=0x13, signed, mem_rdata=0x112233F0, MOC at T+1 -> rdata=0xFFFFFFF0 at T+2. Same request with unsign=1 -> 0x000000F0. With BIG_ENDIAN=0 -> 0x00000011.
3. Half store addr=0x22, wdata=0x0000ABCD -> mem_wdata=0xABCDABCD, mem_be=0011 (BE). Half load addr=0x21 -> done+err at T+1, err_cause=01, mem_enable never high.
4. Load with mem_moc held 0, TIMEOUT=15 -> mem_enable high exactly 15 cycles, then done, err_cause=10, rdata unchanged. size=11 -> err_cause=11.
5. MOC held high 4 cycles after completion -> single done pulse, busy stays high in RELEASE until MOC falls. A req during busy is ignored.
6. Reset asserted mid-ACCESS -> next cycle IDLE, mem_enable=0, busy=0, no done pulse.

Source files
------------

// File: rtl/mem_bus_unit.sv
// mem_bus_unit: multicycle load/store controller sitting between the CPU
// control FSM and a level-handshake (MOC) memory.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   req, wr, size,      one load/store request from the control FSM,
//   unsign, addr,       sampled only while idle (address/data are
//   wdata               registered here, taking the MAR/MDR role)
//   busy, done, err,    status back to the control unit; done is a single
//   err_cause, rdata    cycle pulse, err_cause/rdata are held between ops
//   mem_enable, mem_rw, memory-side request: enable, 1=read/0=write,
//   mem_addr, mem_wdata word address, lane-replicated data, byte enables
//   mem_be
//   mem_rdata, mem_moc  memory read word and operation-complete level
module mem_bus_unit #(
  parameter int ADDR_W     = 32,
  parameter int TIMEOUT    = 15,
  parameter int CNT_W      = 4,
  parameter int BIG_ENDIAN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic              unsign,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_cause,
  output logic [31:0]       rdata,
  output logic              mem_enable,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_moc
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ACCESS   = 2'd1;
  localparam logic [1:0] COMPLETE = 2'd2;
  localparam logic [1:0] RELEASE  = 2'd3;

  localparam logic [1:0] CAUSE_OK    = 2'b00;
  localparam logic [1:0] CAUSE_ALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TMO   = 2'b10;
  localparam logic [1:0] CAUSE_SIZE  = 2'b11;

  // Counter value seen during the last ACCESS cycle before timing out.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic              unsign_q, unsign_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        err_cause_q, err_cause_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;

  // Byte lane index (bit group 8L+7:8L) addressed by the low address bits.
  function automatic logic [1:0] byte_lane(input logic [1:0] a);
    return (BIG_ENDIAN != 0) ? (2'd3 - a) : a;
  endfunction

  // True when the addressed halfword lives in bits [31:16].
  function automatic logic half_hi(input logic [1:0] a);
    return (BIG_ENDIAN != 0) ? ~a[1] : a[1];
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   return 4'b0001 << byte_lane(a);
      2'b01:   return half_hi(a) ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] w);
    case (sz)
      2'b00:   return {4{w[7:0]}};
      2'b01:   return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] rd, input logic [1:0] sz,
                                              input logic uns, input logic [1:0] a);
    logic [31:0] shifted;
    logic [15:0] hw;
    shifted = rd >> {byte_lane(a), 3'b000};
    hw      = half_hi(a) ? rd[31:16] : rd[15:0];
    case (sz)
      2'b00:   return uns ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   return uns ? {16'h0, hw} : {{16{hw[15]}}, hw};
      default: return rd;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    size_d      = size_q;
    unsign_d    = unsign_q;
    addr_lo_d   = addr_lo_q;
    cnt_d       = cnt_q;
    err_cause_d = err_cause_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          wr_d        = wr;
          size_d      = size;
          unsign_d    = unsign;
          addr_lo_d   = addr[1:0];
          mem_addr_d  = {addr[ADDR_W-1:2], 2'b00};
          mem_wdata_d = store_data(size, wdata);
          mem_be_d    = wr ? store_be(size, addr[1:0]) : 4'b1111;
          cnt_d       = '0;
          // Rejected requests skip the memory entirely and report next cycle.
          if (size == 2'b11) begin
            err_cause_d = CAUSE_SIZE;
            state_d     = COMPLETE;
          end else if ((size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00)) begin
            err_cause_d = CAUSE_ALIGN;
            state_d     = COMPLETE;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        // MOC takes priority over a timeout landing on the same cycle.
        if (mem_moc) begin
          if (!wr_q) rdata_d = load_extend(mem_rdata, size_q, unsign_q, addr_lo_q);
          err_cause_d = CAUSE_OK;
          state_d     = COMPLETE;
        end else if (cnt_q == CNT_LAST) begin
          err_cause_d = CAUSE_TMO;
          state_d     = COMPLETE;
        end
      end
      COMPLETE: state_d = mem_moc ? RELEASE : IDLE;
      // MOC is a level; wait for it to drop so one access can't complete twice.
      default:  if (!mem_moc) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      size_q      <= 2'b00;
      unsign_q    <= 1'b0;
      addr_lo_q   <= 2'b00;
      cnt_q       <= '0;
      err_cause_q <= CAUSE_OK;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      size_q      <= size_d;
      unsign_q    <= unsign_d;
      addr_lo_q   <= addr_lo_d;
      cnt_q       <= cnt_d;
      err_cause_q <= err_cause_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == COMPLETE);
  assign err        = done && (err_cause_q != CAUSE_OK);
  assign err_cause  = err_cause_q;
  assign rdata      = rdata_q;
  assign mem_enable = (state_q == ACCESS);
  assign mem_rw     = (state_q == ACCESS) ? ~wr_q : 1'b1;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_be     = mem_be_q;

endmodule

// File: tb/tb_mem_bus_unit.sv
// Directed bench for mem_bus_unit: a big-endian and a little-endian instance
// share the same stimulus so lane selection can be compared side by side.
module tb_mem_bus_unit;

  logic        clk = 1'b0;
  logic        reset, req, wr, unsign, mem_moc;
  logic [1:0]  size;
  logic [31:0] addr, wdata, mem_rdata;

  logic        busy_b, done_b, err_b, en_b, rw_b;
  logic [1:0]  cause_b;
  logic [31:0] rdata_b, maddr_b, mwdata_b;
  logic [3:0]  be_b;
  logic        busy_l, done_l, err_l, en_l, rw_l;
  logic [1:0]  cause_l;
  logic [31:0] rdata_l, maddr_l, mwdata_l;
  logic [3:0]  be_l;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mem_bus_unit #(.ADDR_W(32), .TIMEOUT(15), .CNT_W(4), .BIG_ENDIAN(1)) dut_be (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .unsign(unsign),
    .addr(addr), .wdata(wdata), .busy(busy_b), .done(done_b), .err(err_b),
    .err_cause(cause_b), .rdata(rdata_b), .mem_enable(en_b), .mem_rw(rw_b),
    .mem_addr(maddr_b), .mem_wdata(mwdata_b), .mem_be(be_b),
    .mem_rdata(mem_rdata), .mem_moc(mem_moc));

  mem_bus_unit #(.ADDR_W(32), .TIMEOUT(15), .CNT_W(4), .BIG_ENDIAN(0)) dut_le (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .unsign(unsign),
    .addr(addr), .wdata(wdata), .busy(busy_l), .done(done_l), .err(err_l),
    .err_cause(cause_l), .rdata(rdata_l), .mem_enable(en_l), .mem_rw(rw_l),
    .mem_addr(maddr_l), .mem_wdata(mwdata_l), .mem_be(be_l),
    .mem_rdata(mem_rdata), .mem_moc(mem_moc));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; wr = w; size = sz; unsign = u; addr = a; wdata = d;
    tick();
    req = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; wr = 1'b0; size = 2'b00; unsign = 1'b0;
    addr = '0; wdata = '0; mem_rdata = '0; mem_moc = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_busy",  32'(busy_b), 32'd0);
    check("rst_done",  32'({done_b, err_b}), 32'd0);
    check("rst_cause", 32'(cause_b), 32'd0);
    check("rst_rdata", rdata_b, 32'h0);
    check("rst_en_rw", 32'({en_b, rw_b}), 32'b01);
    check("rst_addr",  maddr_b, 32'h0);
    check("rst_wdata", mwdata_b, 32'h0);
    check("rst_be",    32'(be_b), 32'h0);
    reset = 1'b0;
    tick();

    // Word store, MOC in the third access cycle
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    check("ws_en1",    32'({en_b, rw_b}), 32'b10);
    check("ws_addr",   maddr_b, 32'h10);
    check("ws_be",     32'(be_b), 32'hF);
    check("ws_wdata",  mwdata_b, 32'hDEADBEEF);
    check("ws_busy",   32'({busy_b, done_b}), 32'b10);
    tick();
    check("ws_en2",    32'(en_b), 32'd1);
    tick();
    check("ws_en3",    32'(en_b), 32'd1);
    mem_moc = 1'b1;
    tick();
    check("ws_done",   32'({done_b, err_b, en_b}), 32'b100);
    mem_moc = 1'b0;
    tick();
    check("ws_idle",   32'({busy_b, done_b}), 32'b00);

    // Byte load 0x13, signed then unsigned, MOC at T+1
    issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    check("bl_en_rw",  32'({en_b, rw_b}), 32'b11);
    check("bl_addr",   maddr_b, 32'h10);
    check("bl_be",     32'(be_b), 32'hF);
    mem_rdata = 32'h112233F0; mem_moc = 1'b1;
    tick();
    check("bl_done",   32'({done_b, err_b}), 32'b10);
    check("bl_rd_s",   rdata_b, 32'hFFFFFFF0);
    check("bl_rd_le",  rdata_l, 32'h00000011);
    mem_moc = 1'b0;
    tick();
    issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    mem_moc = 1'b1;
    tick();
    check("bl_rd_u",   rdata_b, 32'h000000F0);
    check("bl_rd_ule", rdata_l, 32'h00000011);
    mem_moc = 1'b0;
    tick();

    // Half store 0x22, then misaligned half load 0x21
    issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000ABCD);
    check("hs_wdata",  mwdata_b, 32'hABCDABCD);
    check("hs_be",     32'(be_b), 32'b0011);
    check("hs_be_le",  32'(be_l), 32'b1100);
    check("hs_addr",   maddr_b, 32'h20);
    mem_moc = 1'b1;
    tick();
    check("hs_done",   32'({done_b, err_b}), 32'b10);
    mem_moc = 1'b0;
    tick();
    issue(1'b0, 2'b01, 1'b0, 32'h21, 32'h0);
    check("mis_done",  32'({done_b, err_b, en_b}), 32'b110);
    check("mis_cause", 32'(cause_b), 32'b01);
    check("mis_rdata", rdata_b, 32'h000000F0);
    tick();
    check("mis_idle",  32'({busy_b, done_b, en_b}), 32'b000);
    check("mis_hold",  32'(cause_b), 32'b01);

    // Timeout: MOC never arrives
    issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    for (int i = 0; i < 15; i++) begin
      check($sformatf("to_en%0d", i), 32'({en_b, done_b}), 32'b10);
      tick();
    end
    check("to_done",   32'({done_b, err_b, en_b}), 32'b110);
    check("to_cause",  32'(cause_b), 32'b10);
    check("to_rdata",  rdata_b, 32'h000000F0);
    tick();

    // Bad size
    issue(1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
    check("bs_done",   32'({done_b, err_b, en_b}), 32'b110);
    check("bs_cause",  32'(cause_b), 32'b11);
    tick();

    // MOC held high after completion; req during busy ignored
    issue(1'b0, 2'b10, 1'b0, 32'h50, 32'h0);
    mem_rdata = 32'h80000001; mem_moc = 1'b1;
    tick();
    check("rl_done",   32'({done_b, err_b}), 32'b10);
    check("rl_rdata",  rdata_b, 32'h80000001);
    req = 1'b1; wr = 1'b1; addr = 32'h60;
    tick();
    req = 1'b0;
    check("rl_hold1",  32'({busy_b, done_b, en_b}), 32'b100);
    tick();
    check("rl_hold2",  32'({busy_b, done_b, en_b}), 32'b100);
    tick();
    check("rl_hold3",  32'({busy_b, done_b, en_b}), 32'b100);
    mem_moc = 1'b0;
    tick();
    check("rl_idle",   32'({busy_b, done_b, en_b}), 32'b000);
    check("rl_noreq",  maddr_b, 32'h50);

    // Reset in the middle of an access
    issue(1'b1, 2'b10, 1'b0, 32'h70, 32'h12345678);
    check("ra_en",     32'(en_b), 32'd1);
    reset = 1'b1;
    tick();
    check("ra_state",  32'({busy_b, done_b, en_b, rw_b}), 32'b0001);
    check("ra_addr",   maddr_b, 32'h0);
    check("ra_rdata",  rdata_b, 32'h0);
    reset = 1'b0;
    tick();
    check("ra_nodone", 32'({busy_b, done_b}), 32'b00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Guard against a stuck simulation.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
